// File: rtl/uart_pkg.sv
// Shared definitions for the full-duplex UART: parity modes, FSM encodings
// and a frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Unused encodings fall back to IDLE through the FSM default branches.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// Transmit state machine: serialises one latched word as start, data (LSB
// first), optional parity and stop bits; one idle cycle after every frame.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 54,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // The done cycle doubles as the mandatory gap between frames.
        if (tx_start && !done_q) begin
          shreg_d = tx_data;
          par_d   = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);
          state_d = TX_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = TX_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = TX_STOP;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: rtl/uart_duplex.sv
// Full-duplex UART top: independent TX engine plus the RX state machine,
// input synchroniser and valid/ack holding register with error flags.
module uart_duplex
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 54,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);

  uart_tx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY      (PARITY),
    .STOP_BITS   (STOP_BITS)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  logic                 meta_q, rx_s_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 pend_perr_q, pend_perr_d;
  logic                 pend_ferr_q, pend_ferr_d;
  logic                 cmp_q, cmp_d;
  logic                 rx_busy_q, rx_busy_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 bit_end, exp_par;

  assign bit_end = (rx_cnt_q == BIT_LAST);
  assign exp_par = (PARITY == PAR_ODD) ? ~(^rx_shreg_q) : (^rx_shreg_q);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 16'd1;
    rx_bit_d    = rx_bit_q;
    rx_shreg_d  = rx_shreg_q;
    pend_perr_d = pend_perr_q;
    pend_ferr_d = pend_ferr_q;
    cmp_d       = 1'b0;
    rx_busy_d   = cmp_q ? 1'b0 : rx_busy_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s_q) begin
          pend_perr_d = 1'b0;
          rx_busy_d   = 1'b1;
          rx_state_d  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          if (rx_s_q) begin
            rx_busy_d  = 1'b0;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_s_q, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            if (PARITY != PAR_NONE) rx_state_d = RX_PARITY;
            else                    rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (bit_end) begin
          rx_cnt_d    = '0;
          pend_perr_d = (rx_s_q != exp_par);
          rx_state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        // Only the first stop bit is checked; a low stop parks in WAIT_HIGH.
        if (bit_end) begin
          rx_cnt_d    = '0;
          cmp_d       = 1'b1;
          pend_ferr_d = ~rx_s_q;
          rx_state_d  = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_busy_d  = 1'b0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
    // A completion coinciding with an ack replaces the word without overrun.
    if (cmp_q) begin
      if (!valid_q || rx_ack) begin
        rx_data_d = rx_shreg_q;
        valid_d   = 1'b1;
        perr_d    = pend_perr_q;
        ferr_d    = pend_ferr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      pend_perr_q <= 1'b0;
      pend_ferr_q <= 1'b0;
      cmp_q       <= 1'b0;
      rx_busy_q   <= 1'b0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      meta_q      <= rx;
      rx_s_q      <= meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      pend_perr_q <= pend_perr_d;
      pend_ferr_q <= pend_ferr_d;
      cmp_q       <= cmp_d;
      rx_busy_q   <= rx_busy_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
    rx_shreg_q <= rx_shreg_d;
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_duplex.sv
// Directed plus randomized bench for uart_duplex, checked against a
// bit-level frame model built from data, parity mode and stop count.
module tb_uart_duplex;

  localparam int C = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rx_drv, loop, rx_ack, tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic       rx_line;
  logic       tx, tx_busy, tx_done, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;
  logic [7:0] rx_data;
  logic       tx2, tx_busy2, tx_done2, rx_valid2, rx_perr2, rx_ferr2, rx_ovr2, rx_busy2;
  logic [7:0] rx_data2;

  int checks = 0;
  int failures = 0;

  assign rx_line = loop ? tx : rx_drv;

  uart_duplex #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rx(rx_line), .tx_data(tx_data), .tx_start(tx_start),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  uart_duplex #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .rx(tx2), .tx_data(tx_data2), .tx_start(tx_start2),
    .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ack(1'b1), .rx_parity_err(rx_perr2), .rx_frame_err(rx_ferr2),
    .rx_overrun(rx_ovr2), .rx_busy(rx_busy2)
  );

  initial begin
    #3000000;
    $fatal(1, "FAIL watchdog: time limit reached checks=%0d", checks);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity value of a word: mode 2 even (popcount parity), mode 1 odd.
  function automatic logic par_of(input logic [7:0] d, input int mode);
    int ones;
    ones = $countones(d);
    return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic run_tx(input string tag, input int which, input logic [7:0] d,
                        input int mode, input int stops);
    logic q[$];
    int c;
    logic got_done, cur_tx, cur_busy, cur_done;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (mode != 0) q.push_back(par_of(d, mode));
    for (int i = 0; i < stops; i++) q.push_back(1'b1);
    if (which == 0) begin tx_data = d; tx_start = 1'b1; end
    else begin tx_data2 = d; tx_start2 = 1'b1; end
    @(negedge clk);
    tx_start = 1'b0;
    tx_start2 = 1'b0;
    c = 0;
    got_done = 1'b0;
    cur_busy = 1'b0;
    while (!got_done && c < 400) begin
      cur_tx   = (which == 0) ? tx : tx2;
      cur_busy = (which == 0) ? tx_busy : tx_busy2;
      cur_done = (which == 0) ? tx_done : tx_done2;
      if (c == 0) chk({tag, "_first_low"}, 32'(cur_tx), 32'd0);
      if ((c % C) == C / 2 && (c / C) < q.size())
        chk($sformatf("%s_bit%0d", tag, c / C), 32'(cur_tx), 32'(q[c / C]));
      if (cur_done) got_done = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({tag, "_done_latency"}, 32'(c), 32'(q.size() * C));
    chk({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'((which == 0) ? tx_done : tx_done2), 32'd0);
  endtask

  task automatic wait_rx(input int max, output logic overlap);
    int w;
    w = 0;
    overlap = 1'b0;
    while (!rx_valid && w < max) begin
      if (rx_busy && tx_busy) overlap = 1'b1;
      @(negedge clk);
      w++;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input logic pbit, input logic sbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(sbit);
    rx_drv = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic       ov;
    logic [7:0] words[5];
    logic [7:0] w;
    int         cnt;
    logic       seen;

    reset = 1'b1; rx_drv = 1'b1; loop = 1'b0; rx_ack = 1'b0;
    tx_start = 1'b0; tx_start2 = 1'b0; tx_data = '0; tx_data2 = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_overrun, rx_busy}), 32'd0);

    run_tx("tx_a5", 0, 8'hA5, 2, 1);
    repeat (3) @(negedge clk);

    // Loopback: fixed corner words plus random ones.
    loop = 1'b1;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h5A;
    words[3] = 8'($urandom); words[4] = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      w = words[k];
      tx_data = w;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_rx(400, ov);
      chk($sformatf("lb%0d_valid", k), 32'(rx_valid), 32'd1);
      chk($sformatf("lb%0d_data", k), 32'(rx_data), 32'(w));
      chk($sformatf("lb%0d_errs", k), 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
      chk($sformatf("lb%0d_overlap", k), 32'(ov), 32'd1);
      ack_pulse();
      chk($sformatf("lb%0d_ack", k), 32'(rx_valid), 32'd0);
      cnt = 0;
      while (tx_busy && cnt < 100) begin @(negedge clk); cnt++; end
      chk($sformatf("lb%0d_tx_idle", k), 32'(tx_busy), 32'd0);
      repeat (3) @(negedge clk);
    end
    loop = 1'b0;
    repeat (4) @(negedge clk);

    // Wrong parity on 0x3C.
    send_bits(8'h3C, ~par_of(8'h3C, 2), 1'b1);
    wait_rx(60, ov);
    chk("perr_valid", 32'(rx_valid), 32'd1);
    chk("perr_data", 32'(rx_data), 32'h3C);
    chk("perr_flag", 32'(rx_parity_err), 32'd1);
    chk("perr_ferr", 32'(rx_frame_err), 32'd0);
    ack_pulse();
    chk("perr_cleared", 32'({rx_valid, rx_parity_err}), 32'd0);

    // Line break for 40 bit times: exactly one word with a frame error.
    rx_drv = 1'b0;
    repeat (40 * C) @(negedge clk);
    chk("brk_valid", 32'(rx_valid), 32'd1);
    chk("brk_ferr", 32'(rx_frame_err), 32'd1);
    chk("brk_data", 32'(rx_data), 32'd0);
    chk("brk_no_second", 32'(rx_overrun), 32'd0);
    ack_pulse();
    rx_drv = 1'b1;
    repeat (6) @(negedge clk);
    chk("brk_after_ack", 32'({rx_valid, rx_busy}), 32'd0);
    w = 8'($urandom);
    send_bits(w, par_of(w, 2), 1'b1);
    wait_rx(60, ov);
    chk("brk_resume_data", 32'({rx_valid, rx_data}), 32'({1'b1, w}));
    chk("brk_resume_errs", 32'({rx_parity_err, rx_frame_err}), 32'd0);
    ack_pulse();
    repeat (4) @(negedge clk);

    // Two frames without ack: first word kept, overrun flagged.
    send_bits(8'h11, par_of(8'h11, 2), 1'b1);
    send_bits(8'h22, par_of(8'h22, 2), 1'b1);
    repeat (20) @(negedge clk);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_flag", 32'(rx_overrun), 32'd1);
    ack_pulse();
    chk("ovr_cleared", 32'({rx_valid, rx_overrun}), 32'd0);
    repeat (4) @(negedge clk);

    // Short low glitch: start detected then rejected at mid-bit.
    rx_drv = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rx_busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("glitch_detected", 32'(seen), 32'd1);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (rx_busy || rx_valid) cnt++;
      @(negedge clk);
    end
    chk("glitch_rejected", 32'(cnt), 32'd0);

    // Reset during data bit 4 of a transmission.
    tx_data = 8'($urandom);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5 * C + C / 2) @(negedge clk);
    chk("rst_mid_busy_before", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      if (tx_done || !tx || rx_valid) cnt++;
      @(negedge clk);
    end
    chk("rst_mid_quiet", 32'(cnt), 32'd0);

    // No parity, two stop bits.
    run_tx("tx2_81", 1, 8'h81, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_duplex.md
Name: uart_duplex

Overview:
Parametrised full-duplex UART, the successor to the single-FSM UART. RX and TX run as independent state machines, so a frame can be received while another is transmitted. Frame format is configurable: data bits, parity and stop bits. Reports parity, framing and overrun errors, and holds received data under a valid/ack handshake. Sits between the host-side byte logic and the board serial pins.

Parameters:
CLKS_PER_BIT, 54, clk cycles per bit; 54 gives 921600 baud at 50 MHz; legal range 8..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits transmitted; legal values 1 or 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx  in  1  serial input, asynchronous to clk
tx_data  in  DATA_BITS  byte to transmit
tx_start  in  1  transmit request, sampled when tx_busy=0
tx  out  1  serial output; idles high
tx_busy  out  1  high while a frame is in flight
tx_done  out  1  one-cycle pulse at frame end
rx_data  out  DATA_BITS  received word, LSB first on line
rx_valid  out  1  rx_data valid; held until rx_ack
rx_ack  in  1  consumer accepts rx_data
rx_parity_err  out  1  parity mismatch on the held word
rx_frame_err  out  1  first stop bit sampled low on the held word
rx_overrun  out  1  sticky: a frame completed while rx_valid=1
rx_busy  out  1  high from start-bit detect to stop-bit sample

Behaviour:
Reset:
- Both FSMs go to IDLE and all counters clear.
- tx=1; all other outputs 0, including rx_data.
- Reset mid-frame aborts the frame. tx returns high on the edge where reset is sampled. No partial rx_valid is produced.

Frame format: start(0), DATA_BITS LSB first, optional parity, STOP_BITS ones. Bit time is exactly CLKS_PER_BIT cycles, counted by a 16-bit counter.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- In IDLE, tx_start=1 latches tx_data and asserts tx_busy. tx drives 0 from the next cycle.
- tx_start while busy is ignored; no queueing.
- Parity bit: even parity = XOR of data bits; odd parity = its inverse.
- After the last stop bit completes, tx_done pulses for 1 cycle and tx_busy falls in the same cycle.
- A new tx_start in that cycle is not accepted. Back-to-back frames are therefore separated by one idle cycle.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
- rx passes through a 2-flop synchronizer to give rx_s. rx_s=0 in IDLE moves to START with cnt=0.
- START samples at cnt=CLKS_PER_BIT/2-1. If rx_s=1 the start is a glitch: return to IDLE with no outputs.
- All later bits are sampled every CLKS_PER_BIT cycles from that midpoint.
- Only the first stop bit is checked, regardless of STOP_BITS.
- One cycle after the stop sample:
  - If rx_valid=0: load rx_data and the error flags, set rx_valid=1, and drop rx_busy.
  - If rx_valid=1: discard the new word, set rx_overrun=1, and leave the held word and flags unchanged.
- Stop sampled 0 (frame error or line break): go to WAIT_HIGH and stay until rx_s=1, then IDLE. A break produces exactly one word.
- rx_ack while rx_valid=1 clears rx_valid, rx_parity_err, rx_frame_err and rx_overrun on the next edge.
- If rx_ack and a new word completion fall in the same cycle, the new word loads, rx_valid stays 1, and no overrun is flagged.
- With PARITY=0, rx_parity_err is always 0.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - TX and RX state encodings, with safe encoding;
  - a function computing frame length in bits.
- One natural sub-module, uart_tx_engine, holds the TX FSM and its bit counter. The RX FSM, synchronizer and handshake stay in the top level.

Test Plan:
All tests use CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1 unless stated.
- TX 0xA5 -> tx low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then parity 0 and stop 1. tx_done pulses 176 cycles after the first tx=0 cycle.
- Loopback tx->rx for 0x00, 0xFF, 0x5A -> each word arrives with rx_valid=1 and no error flags. During each frame rx_busy and tx_busy overlap.
- 0x3C driven with wrong parity -> rx_data=0x3C, rx_parity_err=1. rx_ack clears the flag on the next cycle.
- Stop bit forced low, line held low for 40 bit times -> one word with rx_frame_err=1, no second word. Reception resumes after rx returns high.
- Two frames 0x11 then 0x22 with no rx_ack -> rx_data=0x11, rx_overrun=1. A 6-cycle rx low pulse yields no rx_busy after START.
- reset asserted mid-TX at bit 4 -> tx=1 on the next edge, tx_busy=0, no tx_done. PARITY=0, STOP_BITS=2 with 0x81 -> frame is 11 bits (176 cycles).
